// File: rtl/concurrency_lock.sv
// -----------------------------------------------------------------------------
// concurrency_lock
//
// Per-line mutual-exclusion arbiter between the CPU-side controller and the
// snoopy-side controller of one cache (snoopy invalidate protocol). Each side
// requests a lock on a (tag, index) line before touching tag/state/data.
// A request is granted right away unless the other side holds, or is
// contending for, the same line with a conflicting access. The only
// same-line pair that never conflicts is CPU read vs BUS_READ. On contention
// the snoopy side wins. A CPU whose waiting line is invalidated by a newly
// granted snoop gets a one-cycle cpuInvalidated pulse.
//
// Optional feature (compile-time macro CONCURRENCY_LOCK_STALL_COUNTER_EN):
//   adds a 16-bit saturating stallCount output. It counts the cycles in which
//   either side sits in WAIT with a conflict.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   cpuRequest/Tag/Index/Write/Release   CPU lock request and release
//   cpuGrant                CPU holds the lock (registered)
//   cpuInvalidated          one-cycle pulse, aligned with the rising snoopyGrant
//   snoopyRequest/Tag/Index/Command/Release   snoopy lock request and release
//   snoopyGrant             snoopy side holds the lock (registered)
//   stallCount              (macro builds only) saturating stall-cycle count
// -----------------------------------------------------------------------------
module concurrency_lock #(
    parameter int TAG_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpuRequest,
    input  logic [TAG_WIDTH-1:0]   cpuTag,
    input  logic [INDEX_WIDTH-1:0] cpuIndex,
    input  logic                   cpuWrite,
    input  logic                   cpuRelease,
    output logic                   cpuGrant,
    output logic                   cpuInvalidated,
    input  logic                   snoopyRequest,
    input  logic [TAG_WIDTH-1:0]   snoopyTag,
    input  logic [INDEX_WIDTH-1:0] snoopyIndex,
    input  logic [1:0]             snoopyCommand,
    input  logic                   snoopyRelease,
    output logic                   snoopyGrant
`ifdef CONCURRENCY_LOCK_STALL_COUNTER_EN
    ,
    output logic [15:0]            stallCount
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } side_state_e;

    localparam logic [1:0] CMD_BUS_READ           = 2'd0;
    localparam logic [1:0] CMD_BUS_INVALIDATE     = 2'd1;
    localparam logic [1:0] CMD_BUS_READ_EXCLUSIVE = 2'd2;

    side_state_e cpu_state;
    side_state_e snoop_state;

    // Line and access type of the current holder, captured when the grant is given.
    logic [TAG_WIDTH-1:0]   cpu_held_tag;
    logic [INDEX_WIDTH-1:0] cpu_held_index;
    logic                   cpu_held_write;
    logic [TAG_WIDTH-1:0]   snoop_held_tag;
    logic [INDEX_WIDTH-1:0] snoop_held_index;
    logic [1:0]             snoop_held_cmd;

    // Same-line pairs conflict unless the pair is CPU read vs BUS_READ.
    function automatic logic pair_conflicts(input logic write, input logic [1:0] cmd);
        return write || (cmd != CMD_BUS_READ);
    endfunction

    // A side that releases this cycle no longer blocks anyone this cycle.
    // That lets a waiter be granted on the edge right after the release.
    logic cpu_hold_live;
    logic snoop_hold_live;
    logic snoop_pending;
    logic snoop_blocked;
    logic cpu_blocked;
    logic snoop_grant_now;
    logic cpu_grant_now;
    logic invalidate_now;

    assign cpu_hold_live   = (cpu_state == HELD) && !cpuRelease;
    assign snoop_hold_live = (snoop_state == HELD) && !snoopyRelease;

    // A snoopy request still competing for the lock. This includes a new
    // request raised in the same cycle as a release. Because the snoopy side
    // has priority, this keeps a waiting CPU out between back-to-back snoops.
    assign snoop_pending = snoopyRequest && ((snoop_state != HELD) || snoopyRelease);

    assign snoop_blocked = cpu_hold_live
                         && (snoopyTag == cpu_held_tag) && (snoopyIndex == cpu_held_index)
                         && pair_conflicts(cpu_held_write, snoopyCommand);

    assign cpu_blocked = (snoop_hold_live
                          && (cpuTag == snoop_held_tag) && (cpuIndex == snoop_held_index)
                          && pair_conflicts(cpuWrite, snoop_held_cmd))
                       || (snoop_pending
                          && (cpuTag == snoopyTag) && (cpuIndex == snoopyIndex)
                          && pair_conflicts(cpuWrite, snoopyCommand));

    // A request made in the release cycle is evaluated only from the next
    // cycle, so a HELD side is never re-granted here.
    assign snoop_grant_now = (snoop_state != HELD) && snoopyRequest && !snoop_blocked;
    assign cpu_grant_now   = (cpu_state != HELD) && cpuRequest && !cpu_blocked;

    assign invalidate_now = snoop_grant_now
                          && ((snoopyCommand == CMD_BUS_INVALIDATE)
                              || (snoopyCommand == CMD_BUS_READ_EXCLUSIVE))
                          && cpuRequest && (cpu_state != HELD)
                          && (cpuTag == snoopyTag) && (cpuIndex == snoopyIndex);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_state        <= IDLE;
            snoop_state      <= IDLE;
            cpuGrant         <= 1'b0;
            snoopyGrant      <= 1'b0;
            cpuInvalidated   <= 1'b0;
            cpu_held_tag     <= '0;
            cpu_held_index   <= '0;
            cpu_held_write   <= 1'b0;
            snoop_held_tag   <= '0;
            snoop_held_index <= '0;
            snoop_held_cmd   <= CMD_BUS_READ;
        end else begin
            cpuInvalidated <= invalidate_now;

            // CPU side FSM. A release without a grant is ignored.
            if (cpu_state == HELD) begin
                if (cpuRelease) begin
                    cpu_state <= IDLE;
                    cpuGrant  <= 1'b0;
                end
            end else if (cpu_grant_now) begin
                cpu_state      <= HELD;
                cpuGrant       <= 1'b1;
                cpu_held_tag   <= cpuTag;
                cpu_held_index <= cpuIndex;
                cpu_held_write <= cpuWrite;
            end else if (cpuRequest) begin
                cpu_state <= WAIT;
            end else begin
                cpu_state <= IDLE;
            end

            // Snoopy side FSM.
            if (snoop_state == HELD) begin
                if (snoopyRelease) begin
                    snoop_state <= IDLE;
                    snoopyGrant <= 1'b0;
                end
            end else if (snoop_grant_now) begin
                snoop_state      <= HELD;
                snoopyGrant      <= 1'b1;
                snoop_held_tag   <= snoopyTag;
                snoop_held_index <= snoopyIndex;
                snoop_held_cmd   <= snoopyCommand;
            end else if (snoopyRequest) begin
                snoop_state <= WAIT;
            end else begin
                snoop_state <= IDLE;
            end
        end
    end

`ifdef CONCURRENCY_LOCK_STALL_COUNTER_EN
    logic stall_now;
    assign stall_now = ((cpu_state == WAIT) && cpuRequest && cpu_blocked)
                    || ((snoop_state == WAIT) && snoopyRequest && snoop_blocked);

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall_now && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end
`endif

endmodule
